// File: rtl/fs_port_arbiter_pkg.sv
// Shared types and constants for the filesystem port arbiter.
// Stats support is compiled in only when FS_ARB_STATS_EN is defined.
package fs_arb_pkg;

    localparam int unsigned MAX_RD_LATENCY = 4;
    localparam int unsigned DRAIN_CNT_W    = 3;
    localparam int unsigned STAT_W         = 16;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_PG   = 2'd1,
        TAG_CPU  = 2'd2
    } owner_tag_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_PG  = 2'd1,
        ST_OWN_CPU = 2'd2,
        ST_DRAIN   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic rden;
        logic wren;
        logic meta;
    } fs_cmd_t;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fs_port_arbiter_if.sv
// Requester and storage-side signals of the filesystem port arbiter.
// master = requesters/storage model, slave = arbiter.
interface fs_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              pg_req;
    logic              pg_rden;
    logic              pg_wren;
    logic              pg_meta;
    logic [ADDR_W-1:0] pg_address;
    logic [DATA_W-1:0] pg_data;
    logic              pg_gnt;
    logic [DATA_W-1:0] pg_q;

    logic              cpu_req;
    logic              cpu_rden;
    logic              cpu_wren;
    logic              cpu_meta;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_q;

    logic              fs_rden;
    logic              fs_wren;
    logic              fs_meta;
    logic [ADDR_W-1:0] fs_address;
    logic [DATA_W-1:0] fs_data;
    logic [DATA_W-1:0] fs_q;

    modport master (
        output pg_req, pg_rden, pg_wren, pg_meta, pg_address, pg_data,
        output cpu_req, cpu_rden, cpu_wren, cpu_meta, cpu_address, cpu_data,
        output fs_q,
        input  pg_gnt, pg_q, cpu_gnt, cpu_q,
        input  fs_rden, fs_wren, fs_meta, fs_address, fs_data
    );

    modport slave (
        input  pg_req, pg_rden, pg_wren, pg_meta, pg_address, pg_data,
        input  cpu_req, cpu_rden, cpu_wren, cpu_meta, cpu_address, cpu_data,
        input  fs_q,
        output pg_gnt, pg_q, cpu_gnt, cpu_q,
        output fs_rden, fs_wren, fs_meta, fs_address, fs_data
    );

endinterface

// File: rtl/fs_port_arbiter_q_router.sv
// Read-return steering: tags each issued read with its owner and routes
// fs_q to that owner RD_LATENCY cycles later; the other q reads as zero.
module fs_q_router
    import fs_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  owner_tag_e        rd_tag,
    input  logic [DATA_W-1:0] fs_q,
    output logic [DATA_W-1:0] pg_q,
    output logic [DATA_W-1:0] cpu_q
);

    owner_tag_e tag_q [RD_LATENCY];
    owner_tag_e tag_d [RD_LATENCY];

    always_comb begin
        tag_d[0] = rd_issue ? rd_tag : TAG_NONE;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Data is live only in the cycle its tag reaches the tail.
    always_comb begin
        pg_q  = '0;
        cpu_q = '0;
        if (tag_q[RD_LATENCY-1] == TAG_PG) begin
            pg_q = fs_q;
        end
        if (tag_q[RD_LATENCY-1] == TAG_CPU) begin
            cpu_q = fs_q;
        end
    end

endmodule

// File: rtl/fs_port_arbiter.sv
// Two-requester arbiter for the single filesystem port (pager has priority).
// Optional statistics outputs are enabled by defining FS_ARB_STATS_EN.
module fs_port_arbiter
    import fs_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FS_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_pg_grants,
    output logic [STAT_W-1:0] stat_cpu_grants,
    output logic [STAT_W-1:0] stat_cpu_wait_max,
`endif
    fs_port_arbiter_if.slave  bus
);

    arb_state_e             state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   pg_gnt_q, pg_gnt_d;
    logic                   cpu_gnt_q, cpu_gnt_d;

    fs_cmd_t                fs_cmd_c;
    logic [ADDR_W-1:0]      fs_addr_c;
    logic [DATA_W-1:0]      fs_data_c;
    owner_tag_e             rd_tag_c;

    // Ownership FSM; the last drain cycle arbitrates directly so the
    // release-to-grant gap is RD_LATENCY+1 cycles.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.pg_req) begin
                    state_d = ST_OWN_PG;
                end else if (bus.cpu_req) begin
                    state_d = ST_OWN_CPU;
                end
            end
            ST_OWN_PG: begin
                if (!bus.pg_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_CNT_W'(RD_LATENCY - 1);
                end
            end
            ST_OWN_CPU: begin
                if (!bus.cpu_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_CNT_W'(RD_LATENCY - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    if (bus.pg_req) begin
                        state_d = ST_OWN_PG;
                    end else if (bus.cpu_req) begin
                        state_d = ST_OWN_CPU;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pg_gnt_d  = (state_d == ST_OWN_PG);
        cpu_gnt_d = (state_d == ST_OWN_CPU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            pg_gnt_q    <= 1'b0;
            cpu_gnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            pg_gnt_q    <= pg_gnt_d;
            cpu_gnt_q   <= cpu_gnt_d;
        end
    end

    // Zero-latency pass-through of the owner's command while its req is held.
    always_comb begin
        fs_cmd_c  = '0;
        fs_addr_c = '0;
        fs_data_c = '0;
        rd_tag_c  = TAG_NONE;
        if (state_q == ST_OWN_PG && bus.pg_req) begin
            fs_cmd_c  = '{rden: bus.pg_rden, wren: bus.pg_wren, meta: bus.pg_meta};
            fs_addr_c = bus.pg_address;
            fs_data_c = bus.pg_data;
            rd_tag_c  = TAG_PG;
        end else if (state_q == ST_OWN_CPU && bus.cpu_req) begin
            fs_cmd_c  = '{rden: bus.cpu_rden, wren: bus.cpu_wren, meta: bus.cpu_meta};
            fs_addr_c = bus.cpu_address;
            fs_data_c = bus.cpu_data;
            rd_tag_c  = TAG_CPU;
        end
    end

    assign bus.fs_rden    = fs_cmd_c.rden;
    assign bus.fs_wren    = fs_cmd_c.wren;
    assign bus.fs_meta    = fs_cmd_c.meta;
    assign bus.fs_address = fs_addr_c;
    assign bus.fs_data    = fs_data_c;
    assign bus.pg_gnt     = pg_gnt_q;
    assign bus.cpu_gnt    = cpu_gnt_q;

    fs_q_router #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_W     (DATA_W)
    ) u_q_router (
        .clk      (clk),
        .rst      (rst),
        .rd_issue (fs_cmd_c.rden),
        .rd_tag   (rd_tag_c),
        .fs_q     (bus.fs_q),
        .pg_q     (bus.pg_q),
        .cpu_q    (bus.cpu_q)
    );

`ifdef FS_ARB_STATS_EN
    logic [STAT_W-1:0] pg_grants_q, pg_grants_d;
    logic [STAT_W-1:0] cpu_grants_q, cpu_grants_d;
    logic [STAT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [STAT_W-1:0] wait_max_q, wait_max_d;

    // Grants count on ownership entry; wait spans cpu_req high without cpu_gnt.
    always_comb begin
        pg_grants_d  = pg_grants_q;
        cpu_grants_d = cpu_grants_q;
        wait_cnt_d   = '0;
        if (state_d == ST_OWN_PG && state_q != ST_OWN_PG) begin
            pg_grants_d = sat_inc(pg_grants_q);
        end
        if (state_d == ST_OWN_CPU && state_q != ST_OWN_CPU) begin
            cpu_grants_d = sat_inc(cpu_grants_q);
        end
        if (bus.cpu_req && !cpu_gnt_q) begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
        wait_max_d = (wait_cnt_d > wait_max_q) ? wait_cnt_d : wait_max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pg_grants_q  <= '0;
            cpu_grants_q <= '0;
            wait_cnt_q   <= '0;
            wait_max_q   <= '0;
        end else begin
            pg_grants_q  <= pg_grants_d;
            cpu_grants_q <= cpu_grants_d;
            wait_cnt_q   <= wait_cnt_d;
            wait_max_q   <= wait_max_d;
        end
    end

    assign stat_pg_grants    = pg_grants_q;
    assign stat_cpu_grants   = cpu_grants_q;
    assign stat_cpu_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_fs_port_arbiter.sv
// Self-checking bench for fs_port_arbiter: directed table, timing sequence,
// and randomized traffic against a timestamp-based reference model.
module tb_fs_port_arbiter;

    localparam int unsigned RL = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fs_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef FS_ARB_STATS_EN
    logic [15:0] stat_pg_grants, stat_cpu_grants, stat_cpu_wait_max;
`endif

    fs_port_arbiter #(.RD_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef FS_ARB_STATS_EN
        .stat_pg_grants    (stat_pg_grants),
        .stat_cpu_grants   (stat_cpu_grants),
        .stat_cpu_wait_max (stat_cpu_wait_max),
`endif
        .bus               (bus)
    );

    typedef struct {
        logic        rst;
        logic        pg_req, pg_rden, pg_wren, pg_meta;
        logic [31:0] pg_addr, pg_data;
        logic        cpu_req, cpu_rden, cpu_wren, cpu_meta;
        logic [31:0] cpu_addr, cpu_data;
        logic [31:0] fs_q;
    } vec_t;

    typedef struct {
        logic        pg_gnt, cpu_gnt, rden, wren;
        logic [31:0] addr, pg_q, cpu_q;
    } exp_t;

    typedef struct {
        vec_t in;
        exp_t ex;
    } row_t;

    typedef struct {
        int due;
        int who;
    } rd_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: owner (0 none, 1 pager, 2 cpu), earliest arbitration
    // cycle, and outstanding reads stamped with their return cycle.
    int  m_owner = 0;
    int  m_free  = 0;
    bit  m_valid = 1'b0;
    rd_t rq[$];
    logic smp_cpu_gnt;
`ifdef FS_ARB_STATS_EN
    int ms_pg = 0, ms_cpu = 0, ms_wrun = 0, ms_wmax = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int active_owner(input vec_t v);
        if (m_owner == 1 && v.pg_req)  return 1;
        if (m_owner == 2 && v.cpu_req) return 2;
        return 0;
    endfunction

    task automatic model_check(input vec_t v);
        int          a;
        logic [31:0] epq, ecq;
        a   = active_owner(v);
        epq = '0;
        ecq = '0;
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                if (rq[i].who == 1) epq = v.fs_q;
                if (rq[i].who == 2) ecq = v.fs_q;
            end
        end
        chk("m_pg_gnt",  32'(bus.pg_gnt),  32'(m_owner == 1));
        chk("m_cpu_gnt", 32'(bus.cpu_gnt), 32'(m_owner == 2));
        chk("m_fs_rden", 32'(bus.fs_rden), (a == 1) ? 32'(v.pg_rden) : (a == 2) ? 32'(v.cpu_rden) : 32'd0);
        chk("m_fs_wren", 32'(bus.fs_wren), (a == 1) ? 32'(v.pg_wren) : (a == 2) ? 32'(v.cpu_wren) : 32'd0);
        chk("m_fs_meta", 32'(bus.fs_meta), (a == 1) ? 32'(v.pg_meta) : (a == 2) ? 32'(v.cpu_meta) : 32'd0);
        chk("m_fs_addr", bus.fs_address,   (a == 1) ? v.pg_addr : (a == 2) ? v.cpu_addr : 32'd0);
        chk("m_fs_data", bus.fs_data,      (a == 1) ? v.pg_data : (a == 2) ? v.cpu_data : 32'd0);
        chk("m_pg_q",    bus.pg_q,  epq);
        chk("m_cpu_q",   bus.cpu_q, ecq);
    endtask

    task automatic model_update(input vec_t v);
        int a;
        int prev;
        a    = active_owner(v);
        prev = m_owner;
        if (v.rst) begin
            m_owner = 0;
            m_free  = cyc + 1;
            rq.delete();
            m_valid = 1'b1;
`ifdef FS_ARB_STATS_EN
            ms_pg = 0; ms_cpu = 0; ms_wrun = 0; ms_wmax = 0;
`endif
        end else begin
            if (a == 1 && v.pg_rden)  rq.push_back('{due: cyc + int'(RL), who: 1});
            if (a == 2 && v.cpu_rden) rq.push_back('{due: cyc + int'(RL), who: 2});
            if (m_owner != 0 && a == 0) begin
                m_owner = 0;
                m_free  = cyc + int'(RL);
            end else if (m_owner == 0 && cyc >= m_free) begin
                m_owner = v.pg_req ? 1 : (v.cpu_req ? 2 : 0);
            end
            while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
`ifdef FS_ARB_STATS_EN
            if (prev == 0 && m_owner == 1 && ms_pg < 65535)  ms_pg++;
            if (prev == 0 && m_owner == 2 && ms_cpu < 65535) ms_cpu++;
            if (v.cpu_req && prev != 2) begin
                if (ms_wrun < 65535) ms_wrun++;
            end else begin
                ms_wrun = 0;
            end
            if (ms_wrun > ms_wmax) ms_wmax = ms_wrun;
`endif
        end
        cyc++;
    endtask

    task automatic step(input vec_t v, input bit has_exp, input exp_t e);
        @(negedge clk);
        rst             = v.rst;
        bus.pg_req      = v.pg_req;   bus.pg_rden  = v.pg_rden;  bus.pg_wren = v.pg_wren;
        bus.pg_meta     = v.pg_meta;  bus.pg_address = v.pg_addr; bus.pg_data = v.pg_data;
        bus.cpu_req     = v.cpu_req;  bus.cpu_rden = v.cpu_rden; bus.cpu_wren = v.cpu_wren;
        bus.cpu_meta    = v.cpu_meta; bus.cpu_address = v.cpu_addr; bus.cpu_data = v.cpu_data;
        bus.fs_q        = v.fs_q;
        #1;
        smp_cpu_gnt = bus.cpu_gnt;
        if (m_valid) model_check(v);
        if (has_exp) begin
            chk("tbl_pg_gnt",  32'(bus.pg_gnt),  32'(e.pg_gnt));
            chk("tbl_cpu_gnt", 32'(bus.cpu_gnt), 32'(e.cpu_gnt));
            chk("tbl_fs_rden", 32'(bus.fs_rden), 32'(e.rden));
            chk("tbl_fs_wren", 32'(bus.fs_wren), 32'(e.wren));
            chk("tbl_fs_addr", bus.fs_address, e.addr);
            chk("tbl_pg_q",    bus.pg_q,  e.pg_q);
            chk("tbl_cpu_q",   bus.cpu_q, e.cpu_q);
        end
        @(posedge clk);
        model_update(v);
    endtask

    function automatic vec_t mkv(input logic r, input logic preq, input logic prd, input logic pwr,
                                 input logic [31:0] pa, input logic creq, input logic crd,
                                 input logic cwr, input logic [31:0] ca, input logic [31:0] fq);
        vec_t v;
        v.rst = r;
        v.pg_req = preq; v.pg_rden = prd; v.pg_wren = pwr; v.pg_meta = 1'b0;
        v.pg_addr = pa;  v.pg_data = pa ^ 32'hD00D_0000;
        v.cpu_req = creq; v.cpu_rden = crd; v.cpu_wren = cwr; v.cpu_meta = 1'b0;
        v.cpu_addr = ca;  v.cpu_data = ca ^ 32'hC0DE_0000;
        v.fs_q = fq;
        return v;
    endfunction

    function automatic exp_t mke(input logic gp, input logic gc, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] pq, input logic [31:0] cq);
        exp_t e;
        e.pg_gnt = gp; e.cpu_gnt = gc; e.rden = rd; e.wren = wr;
        e.addr = a; e.pg_q = pq; e.cpu_q = cq;
        return e;
    endfunction

    row_t tbl[$];
    exp_t e0;

    initial begin
        vec_t v;
        logic pgr, cpr;
        int   k_found;

        e0 = mke(0, 0, 0, 0, 0, 0, 0);
        //                 rst preq prd pwr pa        creq crd cwr ca     fs_q            gp gc rd wr addr     pg_q     cpu_q
        tbl.push_back('{mkv(0, 1, 0, 0, 32'h3FF, 1, 0, 0, 32'h0,  32'h0),      mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h400, 1, 0, 0, 32'h0,  32'h0),      mke(1, 0, 1, 0, 32'h400, 32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h401, 1, 0, 0, 32'h0,  32'h0),      mke(1, 0, 1, 0, 32'h401, 32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h402, 1, 0, 1, 32'h20, 32'h500),    mke(1, 0, 1, 0, 32'h402, 32'h500, 32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h403, 1, 0, 1, 32'h20, 32'h501),    mke(1, 0, 1, 0, 32'h403, 32'h501, 32'h0)});
        tbl.push_back('{mkv(0, 1, 0, 1, 32'h404, 1, 0, 1, 32'h20, 32'h502),    mke(1, 0, 0, 1, 32'h404, 32'h502, 32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h405, 1, 0, 1, 32'h20, 32'h503),    mke(1, 0, 0, 0, 32'h0,   32'h503, 32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h20, 32'h777),    mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h20, 32'h778),    mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   1, 1, 0, 32'h10, 32'h0),      mke(0, 1, 1, 0, 32'h10,  32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 0, 0, 32'h700, 0, 1, 0, 32'h11, 32'h0),      mke(0, 1, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 0, 0, 32'h700, 0, 0, 0, 32'h0,  32'hABCD),   mke(0, 0, 0, 0, 32'h0,   32'h0,   32'hABCD)});
        tbl.push_back('{mkv(0, 1, 0, 0, 32'h700, 1, 0, 0, 32'h0,  32'h1234),   mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h600, 1, 0, 0, 32'h0,  32'h0),      mke(1, 0, 1, 0, 32'h600, 32'h0,   32'h0)});
        tbl.push_back('{mkv(1, 1, 1, 0, 32'h601, 1, 0, 0, 32'h0,  32'h0),      mke(1, 0, 1, 0, 32'h601, 32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h602, 0, 0, 0, 32'h0,  32'hBEEF),   mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 1, 1, 0, 32'h603, 0, 0, 0, 32'h0,  32'hCAFE),   mke(1, 0, 1, 0, 32'h603, 32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h1111),   mke(1, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h5555),   mke(0, 0, 0, 0, 32'h0,   32'h5555, 32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h0,  32'h0),      mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h30, 32'h0),      mke(0, 1, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0),      mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});
        tbl.push_back('{mkv(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0),      mke(0, 0, 0, 0, 32'h0,   32'h0,   32'h0)});

        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, e0);
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, e0);
        foreach (tbl[i]) step(tbl[i].in, 1'b1, tbl[i].ex);

        // Release-to-grant timing: pager owns, drops, CPU waiting throughout.
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, e0);
        for (int i = 0; i < 4; i++) step(mkv(0, 1, 0, 0, 32'h40, 1, 0, 0, 0, 0), 1'b0, e0);
        k_found = 99;
        for (int k = 0; k < 10; k++) begin
            step(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, e0);
            if (smp_cpu_gnt === 1'b1) begin
                k_found = k;
                break;
            end
        end
        chk("switch_time", 32'(k_found), 32'(RL + 1));
`ifdef FS_ARB_STATS_EN
        #1;
        chk("stat_pg_grants_seq",  32'(stat_pg_grants),    32'd1);
        chk("stat_cpu_grants_seq", 32'(stat_cpu_grants),   32'd1);
        chk("stat_wait_max_seq",   32'(stat_cpu_wait_max), 32'(4 + RL + 1));
`endif

        // Randomized traffic with persistent requests and occasional resets.
        pgr = 1'b0;
        cpr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) pgr = ~pgr;
            if ($urandom_range(0, 4) == 0) cpr = ~cpr;
            v.rst      = ($urandom_range(0, 249) == 0);
            v.pg_req   = pgr;
            v.pg_rden  = 1'($urandom_range(0, 1));
            v.pg_wren  = 1'($urandom_range(0, 1));
            v.pg_meta  = 1'($urandom_range(0, 1));
            v.pg_addr  = $urandom;
            v.pg_data  = $urandom;
            v.cpu_req  = cpr;
            v.cpu_rden = 1'($urandom_range(0, 1));
            v.cpu_wren = 1'($urandom_range(0, 1));
            v.cpu_meta = 1'($urandom_range(0, 1));
            v.cpu_addr = $urandom;
            v.cpu_data = $urandom;
            v.fs_q     = $urandom;
            step(v, 1'b0, e0);
        end

`ifdef FS_ARB_STATS_EN
        #1;
        chk("stat_pg_grants",  32'(stat_pg_grants),    32'(ms_pg));
        chk("stat_cpu_grants", 32'(stat_cpu_grants),   32'(ms_cpu));
        chk("stat_wait_max",   32'(stat_cpu_wait_max), 32'(ms_wmax));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
